// File: rtl/cla_seq_addsub_if.sv
// rtl/cla_seq_addsub_if.sv - operand/result handshake bundle for the sequential CLA adder/subtractor
interface cla_seq_addsub_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             op_sub;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             zero;

  // Producer of operations and consumer of results
  modport master (
    output in_valid, a, b, op_sub, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, zero
  );

  // The arithmetic block itself
  modport slave (
    input  in_valid, a, b, op_sub, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf, zero
  );
endinterface

// File: rtl/cla_seq_addsub.sv
// rtl/cla_seq_addsub.sv - multi-cycle adder/subtractor resolving one carry-lookahead slice per clock
module cla_seq_addsub #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input logic            clk,
  input logic            rst_n,
  cla_seq_addsub_if.slave bus
);

  localparam int NSL = (SLICE > 0) ? (WIDTH / SLICE) : 1;
  localparam int CW  = (NSL > 1) ? $clog2(NSL) : 1;
  localparam logic [CW-1:0] K_LAST = CW'(NSL - 1);

  // Reject widths that cannot be split into whole slices
  generate
    if (WIDTH <= 0 || SLICE <= 0 || ((SLICE > 0) ? (WIDTH % SLICE) : 1) != 0) begin : g_bad_cfg
      $error("cla_seq_addsub: WIDTH must be a positive multiple of SLICE");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, sum_q;
  logic             carry_q;
  logic [CW-1:0]    k_q;
  logic             cout_q, ovf_q, zero_q;
  logic             in_ready_c, out_valid_c;

  logic [SLICE-1:0] p, g;
  logic [SLICE:0]   c;
  logic [WIDTH-1:0] sum_next;

  // Current slice: propagate/generate, flattened lookahead carries and the merged sum
  always_comb begin
    int   base;
    logic term;
    base     = int'(k_q) * SLICE;
    p        = a_q[base +: SLICE] ^ b_q[base +: SLICE];
    g        = a_q[base +: SLICE] & b_q[base +: SLICE];
    c        = '0;
    term     = 1'b0;
    c[0]     = carry_q;
    for (int i = 1; i <= SLICE; i++) begin
      // carry-in propagated through every lower bit
      term = carry_q;
      for (int j = 0; j < i; j++) term = term & p[j];
      c[i] = term;
      // generate at bit j propagated through bits j+1 .. i-1
      for (int j = 0; j < i; j++) begin
        term = g[j];
        for (int m = j + 1; m < i; m++) term = term & p[m];
        c[i] = c[i] | term;
      end
    end
    sum_next                   = sum_q;
    sum_next[base +: SLICE]    = p ^ c[SLICE-1:0];
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state and handshake outputs
  always_comb begin
    state_d     = state_q;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) state_d = RUN;
      end
      RUN: begin
        if (k_q == K_LAST) state_d = DONE;
      end
      DONE: begin
        out_valid_c = 1'b1;
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand capture, per-slice accumulation and final flag registration
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      k_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            a_q     <= bus.a;
            // subtract is A + ~B + 1, the +1 entering as the initial carry
            b_q     <= bus.op_sub ? ~bus.b : bus.b;
            carry_q <= bus.op_sub ? 1'b1 : bus.cin;
            k_q     <= '0;
            sum_q   <= '0;
          end
        end
        RUN: begin
          sum_q   <= sum_next;
          carry_q <= c[SLICE];
          if (k_q == K_LAST) begin
            cout_q <= c[SLICE];
            ovf_q  <= c[SLICE] ^ c[SLICE-1];
            zero_q <= (sum_next == '0);
          end else begin
            k_q <= k_q + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;
  assign bus.zero      = zero_q;

endmodule

// File: tb/tb_cla_seq_addsub.sv
// tb/tb_cla_seq_addsub.sv - scoreboard bench for cla_seq_addsub
module tb_cla_seq_addsub;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic        cin;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
  } vec_t;

  typedef struct {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
    int          acc;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_checks;
  int   n_pass;
  int   n_acc;
  int   n_hs;
  logic auto_rdy;
  logic rand_rdy;
  logic ov_prev;
  exp_t sb[$];
  vec_t tbl[10];

  cla_seq_addsub_if #(.WIDTH(16)) bus ();

  cla_seq_addsub #(.WIDTH(16), .SLICE(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
  endtask

  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                 input logic s, input logic c);
    logic [16:0] r;
    exp_t        e;
    if (s) r = {1'b0, a} + {1'b0, ~b} + 17'd1;
    else   r = {1'b0, a} + {1'b0, b} + {16'd0, c};
    e.sum  = r[15:0];
    e.cout = r[16];
    e.ovf  = s ? ((a[15] != b[15]) && (r[15] != a[15]))
               : ((a[15] == b[15]) && (r[15] != a[15]));
    e.zero = (r[15:0] == 16'd0);
    e.acc  = 0;
    return e;
  endfunction

  // out_ready driver when the test is not steering it by hand
  always @(posedge clk) begin
    #1;
    if (auto_rdy) bus.out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Result monitor: latency on out_valid rise, scoreboard compare on handshake
  always @(negedge clk) begin
    if (!rst_n) begin
      ov_prev = 1'b0;
    end else begin
      if (bus.out_valid && !ov_prev) begin
        if (sb.size() == 0) chk("spurious_out_valid", 32'd1, 32'd0);
        else chk("latency", 32'(cyc - sb[0].acc), 32'd4);
      end
      ov_prev = bus.out_valid;
      if (bus.out_valid && bus.out_ready) begin
        n_hs++;
        if (sb.size() == 0) begin
          chk("unexpected_result", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("sum",  32'(bus.sum),  32'(e.sum));
          chk("cout", 32'(bus.cout), 32'(e.cout));
          chk("ovf",  32'(bus.ovf),  32'(e.ovf));
          chk("zero", 32'(bus.zero), 32'(e.zero));
        end
      end
    end
  end

  // Present one operation and hold it until accepted; starts and ends at posedge+1
  task automatic issue(input logic [15:0] a_i, input logic [15:0] b_i,
                       input logic s_i, input logic c_i, input exp_t e);
    bit got;
    got = 0;
    bus.a = a_i; bus.b = b_i; bus.op_sub = s_i; bus.cin = c_i;
    bus.in_valid = 1'b1;
    for (int t = 0; t < 100 && !got; t++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        e.acc = cyc + 1;
        sb.push_back(e);
        n_acc++;
        got = 1;
      end
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    if (!got) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    for (int t = 0; t < 300 && sb.size() != 0; t++) begin
      @(posedge clk); #1;
    end
    chk("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"},  32'(bus.in_ready),  32'd1);
    chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_sum"},       32'(bus.sum),       32'd0);
    chk({tag, "_flags"},     32'({bus.cout, bus.ovf, bus.zero}), 32'd0);
  endtask

  initial begin
    exp_t        e;
    logic [15:0] s0;
    logic [2:0]  f0;
    bit          seen;
    bit          got;

    n_checks = 0; n_pass = 0; n_acc = 0; n_hs = 0; cyc = 0;
    ov_prev = 1'b0;
    auto_rdy = 1'b1; rand_rdy = 1'b0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.op_sub = 1'b0; bus.cin = 1'b0;
    bus.out_ready = 1'b1;

    //             a         b         sub   cin   sum       cout  ovf   zero
    tbl[0] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
    tbl[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b0};
    tbl[4] = '{16'h0003, 16'h0005, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0001, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
    tbl[7] = '{16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0};
    tbl[8] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};
    tbl[9] = '{16'h0000, 16'h8000, 1'b1, 1'b1, 16'h8000, 1'b0, 1'b1, 1'b0};

    #12;
    chk_reset_outputs("por");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vectors
    for (int i = 0; i < 10; i++) begin
      e.sum = tbl[i].sum; e.cout = tbl[i].cout; e.ovf = tbl[i].ovf; e.zero = tbl[i].zero; e.acc = 0;
      issue(tbl[i].a, tbl[i].b, tbl[i].sub, tbl[i].cin, e);
    end
    drain();

    // Stall in DONE with in_valid and operands wiggling
    auto_rdy = 1'b0;
    bus.out_ready = 1'b0;
    issue(16'hA5A5, 16'h0F0F, 1'b0, 1'b0, model(16'hA5A5, 16'h0F0F, 1'b0, 1'b0));
    got = 0;
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge clk);
      if (bus.out_valid) got = 1;
    end
    chk("stall_reach_done", 32'(got), 32'd1);
    s0 = bus.sum;
    f0 = {bus.cout, bus.ovf, bus.zero};
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      bus.in_valid = 1'b1;
      bus.a = 16'($urandom); bus.b = 16'($urandom); bus.op_sub = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("stall_sum",       32'(bus.sum), 32'(s0));
      chk("stall_flags",     32'({bus.cout, bus.ovf, bus.zero}), 32'(f0));
      chk("stall_in_ready",  32'(bus.in_ready),  32'd0);
      chk("stall_out_valid", 32'(bus.out_valid), 32'd1);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("post_stall_in_ready",  32'(bus.in_ready),  32'd1);
    chk("post_stall_out_valid", 32'(bus.out_valid), 32'd0);
    auto_rdy = 1'b1;
    seen = 0;
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      if (bus.out_valid || !bus.in_ready) seen = 1;
    end
    chk("stall_no_accept", 32'(seen), 32'd0);
    chk("stall_sb_empty", 32'(sb.size()), 32'd0);
    @(posedge clk); #1;

    // Reset in the middle of RUN
    issue(16'h1111, 16'h2222, 1'b0, 1'b0, model(16'h1111, 16'h2222, 1'b0, 1'b0));
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("mid_run_rst");
    n_acc -= sb.size();
    sb.delete();
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk_reset_outputs("held_rst");
    rst_n = 1'b1;
    @(posedge clk); #1;
    issue(16'h00FF, 16'h0001, 1'b0, 1'b0, model(16'h00FF, 16'h0001, 1'b0, 1'b0));
    drain();

    // Random back-to-back traffic with random consumer stalls
    rand_rdy = 1'b1;
    for (int i = 0; i < 40; i++) begin
      logic [15:0] ra, rb;
      logic        rs, rc;
      ra = 16'($urandom); rb = 16'($urandom);
      rs = 1'($urandom_range(0, 1)); rc = 1'($urandom_range(0, 1));
      if (i % 8 == 0) ra = 16'hFFFF;
      if (i % 8 == 1) rb = 16'h8000;
      if (i % 8 == 2) ra = 16'h0000;
      issue(ra, rb, rs, rc, model(ra, rb, rs, rc));
    end
    drain();
    rand_rdy = 1'b0;

    chk("handshakes_per_accept", 32'(n_hs), 32'(n_acc));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cla_seq_addsub.md
CLA_SEQ_ADDSUB -- requirements
Module: cla_seq_addsub

Interface
REQ-001 Parameter WIDTH, default 16, operand and result width in bits.
REQ-002 Parameter SLICE, default 4, bits resolved per cycle by one carry-lookahead slice.
REQ-003 WIDTH SHALL be a positive multiple of SLICE; NSL = WIDTH/SLICE is the number of slices; any other combination SHALL be an elaboration error.
REQ-004 clk  input  1  single clock, rising-edge active.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  operands and opcode on a, b, op_sub, cin are valid.
REQ-007 in_ready  output  1  block can accept an operation.
REQ-008 a  input  WIDTH  operand A.
REQ-009 b  input  WIDTH  operand B.
REQ-010 op_sub  input  1  0 = A+B+cin; 1 = A-B (cin ignored).
REQ-011 cin  input  1  carry-in for add.
REQ-012 out_valid  output  1  result outputs are valid.
REQ-013 out_ready  input  1  consumer accepts the result.
REQ-014 sum  output  WIDTH  result.
REQ-015 cout  output  1  carry out of the MSB (for subtract, 1 = no borrow).
REQ-016 ovf  output  1  two's-complement signed overflow.
REQ-017 zero  output  1  sum == 0.

Function
REQ-018 FSM states: IDLE, RUN, DONE. in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-019 Acceptance occurs on a rising edge with in_valid=1 and in_ready=1.
- Latch a into the A register.
- Latch b, or ~b when op_sub=1, into the B register.
- Initialise the carry register to cin for add, or to 1 for subtract.
- Clear the slice counter and sum, then move to RUN.
REQ-020 In RUN, each cycle SHALL process slice k (bits k*SLICE .. k*SLICE+SLICE-1).
- Compute per-bit P=A^B and G=A&B.
- Compute every internal carry by lookahead from the carry register (no ripple across cycles within a slice).
- Write the slice sum bits P^C into sum, register the slice carry-out, and increment k.
REQ-021 On the edge that processes slice NSL-1:
- register cout = the slice carry-out;
- register ovf = (carry into the MSB) XOR (carry out of the MSB);
- register zero = (final sum == 0);
- move to DONE.
REQ-022 Latency: out_valid SHALL rise exactly NSL clock edges after the accepting edge (4 for the defaults); there is no overlap of operations.
REQ-023 In DONE, sum, cout, ovf and zero SHALL hold stable until an edge with out_ready=1; that edge SHALL return the FSM to IDLE.
REQ-024 in_valid SHALL be ignored outside IDLE; a, b, op_sub and cin are sampled only at acceptance, so changing them later SHALL have no effect.
REQ-025 out_ready SHALL be ignored outside DONE.
REQ-026 Arithmetic SHALL be modulo 2^WIDTH; cout and ovf SHALL follow REQ-021 for all operand values, including all-ones, 0x80..0 and zero operands.
REQ-027 The slice counter SHALL be ceil(log2(NSL)) bits wide, minimum 1, and SHALL not wrap in normal operation (cleared on acceptance).

Reset
REQ-028 While rst_n=0, at any time including mid-RUN:
- state = IDLE;
- in_ready = 1, out_valid = 0;
- sum, cout, ovf and zero = 0;
- internal A, B, carry and counter registers = 0.
REQ-029 An operation interrupted by reset SHALL be discarded, with no out_valid for it.
REQ-030 The first acceptance after rst_n rises SHALL behave exactly as REQ-019.

Verification (WIDTH=16, SLICE=4)
REQ-031 Add 0x1234+0x4321, cin=0 -> out_valid 4 edges after acceptance; sum=0x5555, cout=0, ovf=0, zero=0.
REQ-032 Add 0xFFFF+0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0, zero=1; also add 0x7FFF+0x0001 -> sum=0x8000, cout=0, ovf=1.
REQ-033 Sub 0x8000-0x0001 -> sum=0x7FFF, cout=1, ovf=1; sub 0x0003-0x0005 -> sum=0xFFFE, cout=0, ovf=0.
REQ-034 Hold out_ready=0 for 3 cycles in DONE while toggling in_valid and a/b -> outputs stable, in_ready=0, no new acceptance; out_ready=1 -> IDLE with in_ready=1 next cycle.
REQ-035 Reset asserted after 2 RUN cycles -> all outputs at reset values immediately; after release, op 0x00FF+0x0001 -> sum=0x0100 in 4 edges with no stale result.
REQ-036 Random add/sub with random cin, back-to-back acceptances and random out_ready stalls -> every result matches a golden model, with exactly one out_valid handshake per accepted operation.
